// File: rtl/chi_link_pkg.sv
// chi_link_pkg: link-activation states and link-flit classification shared by the CHI link endpoint
package chi_link_pkg;
  typedef enum logic [1:0] {LA_STOP, LA_ACTIVATE, LA_RUN, LA_DEACTIVATE} la_state_e;
  localparam logic [31:0] LINK_OPCODE = 32'd0;
  function automatic logic is_link_flit(input logic [31:0] opcode);
    return opcode == LINK_OPCODE;
  endfunction
endpackage

// File: rtl/chi_link_rxfifo.sv
// chi_link_rxfifo: synchronous FIFO buffering received protocol flits for the local agent
module chi_link_rxfifo #(
  parameter int W = 128,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic [3:0]   count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign valid = count != '0;
  assign dout = valid ? mem[rd_ptr] : '0;
  assign do_pop = pop & valid;
  // a pop in the same cycle frees the slot, so push-while-full is accepted then
  assign do_push = push & ((count != 4'(DEPTH)) | do_pop);
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      count <= count + 4'(do_push) - 4'(do_pop);
    end
endmodule

// File: rtl/chi_link_endpoint.sv
// chi_link_endpoint: device-side CHI link endpoint; TX/RX link activation, L-credit flow control, RX buffering
module chi_link_endpoint
  import chi_link_pkg::*;
#(
  parameter int FLIT_WIDTH = 128,
  parameter int OPCODE_OFFSET = 0,
  parameter int OPCODE_WIDTH = 7,
  parameter int TX_CRD_MAX = 15,
  parameter int RX_CRD_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  link_en,
  output logic                  TXLINKACTIVEREQ,
  input  logic                  TXLINKACTIVEACK,
  input  logic                  RXLINKACTIVEREQ,
  output logic                  RXLINKACTIVEACK,
  output logic                  TXSACTIVE,
  output logic                  TXFLITV,
  output logic [FLIT_WIDTH-1:0] TXFLIT,
  input  logic                  TXLCRDV,
  input  logic                  RXFLITV,
  input  logic [FLIT_WIDTH-1:0] RXFLIT,
  output logic                  RXLCRDV,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [FLIT_WIDTH-1:0] tx_flit,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [FLIT_WIDTH-1:0] rx_flit,
  output logic                  proto_err
);
  la_state_e tx_state, tx_next, rx_state, rx_next;
  logic [3:0] tx_crd, rx_out, fifo_count;
  logic tx_hs, tx_link, tx_spend, tx_crd_err, tx_crd_in;
  logic rx_grant, rx_err, rx_take, rx_push;
  assign tx_ready = (tx_state == LA_RUN) && (tx_crd != '0);
  assign tx_hs = tx_valid & tx_ready;
  // deactivation drains every held credit back to the peer as all-zero link flits
  assign tx_link = (tx_state == LA_DEACTIVATE) && (tx_crd != '0);
  assign tx_spend = tx_hs | tx_link;
  assign tx_crd_err = TXLCRDV & ((tx_state == LA_STOP) || (tx_crd == 4'(TX_CRD_MAX)));
  assign tx_crd_in = TXLCRDV & ~tx_crd_err;
  assign TXLINKACTIVEREQ = (tx_state == LA_ACTIVATE) || (tx_state == LA_RUN);
  assign TXSACTIVE = tx_state != LA_STOP;
  assign RXLINKACTIVEACK = rx_state != LA_STOP;
  // credits in flight plus buffered flits never exceed the buffer depth
  assign rx_grant = (rx_state == LA_RUN) && (5'(rx_out) + 5'(fifo_count) < 5'(RX_CRD_NUM));
  assign rx_err = RXFLITV & (rx_out == '0);
  assign rx_take = RXFLITV & ~rx_err;
  assign rx_push = rx_take & ~is_link_flit(32'(RXFLIT[OPCODE_OFFSET +: OPCODE_WIDTH]));
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      LA_STOP: if (link_en && rx_state != LA_DEACTIVATE) tx_next = LA_ACTIVATE;
      LA_ACTIVATE: if (TXLINKACTIVEACK) tx_next = LA_RUN;
      LA_RUN: if (!link_en) tx_next = LA_DEACTIVATE;
      default: if (!TXLINKACTIVEACK && tx_crd == '0) tx_next = LA_STOP;
    endcase
  end
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      LA_STOP: if (RXLINKACTIVEREQ) rx_next = LA_RUN;
      LA_RUN: if (!RXLINKACTIVEREQ) rx_next = LA_DEACTIVATE;
      LA_DEACTIVATE: if (rx_out == '0) rx_next = LA_STOP;
      default: rx_next = LA_STOP;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      tx_state <= LA_STOP;
      rx_state <= LA_STOP;
      tx_crd <= '0;
      rx_out <= '0;
      TXFLITV <= 1'b0;
      TXFLIT <= '0;
      RXLCRDV <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      tx_state <= tx_next;
      rx_state <= rx_next;
      tx_crd <= tx_crd + 4'(tx_crd_in) - 4'(tx_spend);
      rx_out <= rx_out + 4'(rx_grant) - 4'(rx_take);
      TXFLITV <= tx_spend;
      TXFLIT <= tx_hs ? tx_flit : '0;
      RXLCRDV <= rx_grant;
      proto_err <= proto_err | tx_crd_err | rx_err;
    end
  chi_link_rxfifo #(.W(FLIT_WIDTH), .DEPTH(RX_CRD_NUM)) u_rxfifo (
    .clk(clk),
    .rst(rst),
    .push(rx_push),
    .din(RXFLIT),
    .pop(rx_ready),
    .valid(rx_valid),
    .dout(rx_flit),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_chi_link_endpoint.sv
// tb_chi_link_endpoint: scenario tests of the CHI link endpoint against a credit/queue reference model
module tb_chi_link_endpoint;
  localparam int FW = 128;
  localparam int CRD_MAX = 15;
  localparam int RXN = 4;
  logic clk = 1'b0;
  logic rst, link_en, TXLINKACTIVEREQ, TXLINKACTIVEACK, RXLINKACTIVEREQ, RXLINKACTIVEACK;
  logic TXSACTIVE, TXFLITV, TXLCRDV, RXFLITV, RXLCRDV, tx_valid, tx_ready, rx_valid, rx_ready, proto_err;
  logic [FW-1:0] TXFLIT, RXFLIT, tx_flit, rx_flit;
  logic [2*FW+7:0] outs;
  int n_cmp = 0, n_bad = 0, m_crd = 0;
  always #5 clk = ~clk;
  assign outs = {TXLINKACTIVEREQ, RXLINKACTIVEACK, TXSACTIVE, TXFLITV, RXLCRDV, tx_ready, rx_valid, proto_err, TXFLIT, rx_flit};
  chi_link_endpoint #(.FLIT_WIDTH(FW), .OPCODE_OFFSET(0), .OPCODE_WIDTH(7), .TX_CRD_MAX(CRD_MAX), .RX_CRD_NUM(RXN)) dut (
    .clk(clk), .rst(rst), .link_en(link_en),
    .TXLINKACTIVEREQ(TXLINKACTIVEREQ), .TXLINKACTIVEACK(TXLINKACTIVEACK),
    .RXLINKACTIVEREQ(RXLINKACTIVEREQ), .RXLINKACTIVEACK(RXLINKACTIVEACK),
    .TXSACTIVE(TXSACTIVE), .TXFLITV(TXFLITV), .TXFLIT(TXFLIT), .TXLCRDV(TXLCRDV),
    .RXFLITV(RXFLITV), .RXFLIT(RXFLIT), .RXLCRDV(RXLCRDV),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_flit(tx_flit),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_flit(rx_flit), .proto_err(proto_err)
  );
  function automatic logic [FW-1:0] rand_flit(input logic link);
    logic [FW-1:0] f;
    f = {$urandom, $urandom, $urandom, $urandom};
    f[6:0] = link ? 7'd0 : 7'($urandom_range(127, 1));
    return f;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    {link_en, TXLINKACTIVEACK, RXLINKACTIVEREQ, TXLCRDV, RXFLITV, tx_valid, rx_ready} = '0;
    tx_flit = '0;
    RXFLIT = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    m_crd = 0;
  endtask
  task automatic bring_up();
    link_en = 1'b1;
    TXLINKACTIVEACK = 1'b1;
    step();
    step();
  endtask
  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    step();
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", outs); end
    rst = 1'b0;
    step();
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL idle_after_reset: got %h want 0", outs); end
  endtask
  task automatic test_bringup();
    link_en = 1'b1;
    step();
    n_cmp++; if ({TXLINKACTIVEREQ, TXSACTIVE, tx_ready} !== 3'b110) begin n_bad++; $display("FAIL bringup_req: got %b want 110", {TXLINKACTIVEREQ, TXSACTIVE, tx_ready}); end
    repeat (3) step();
    n_cmp++; if ({TXLINKACTIVEREQ, TXSACTIVE, tx_ready} !== 3'b110) begin n_bad++; $display("FAIL bringup_wait: got %b want 110", {TXLINKACTIVEREQ, TXSACTIVE, tx_ready}); end
    TXLINKACTIVEACK = 1'b1;
    step();
    n_cmp++; if ({TXLINKACTIVEREQ, TXSACTIVE, tx_ready, proto_err} !== 4'b1100) begin n_bad++; $display("FAIL bringup_run: got %b want 1100", {TXLINKACTIVEREQ, TXSACTIVE, tx_ready, proto_err}); end
    TXLCRDV = 1'b1;
    step();
    TXLCRDV = 1'b0;
    m_crd = 1;
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL bringup_credit: tx_ready got %b want 1", tx_ready); end
  endtask
  task automatic test_tx_credits();
    int n, tries, sent;
    logic exp_v;
    logic [FW-1:0] f;
    n = $urandom_range(7, 3);
    repeat (n) begin TXLCRDV = 1'b1; step(); end
    TXLCRDV = 1'b0;
    m_crd += n;
    tries = m_crd + 2;
    sent = 0;
    for (int k = 0; k < tries; k++) begin
      f = rand_flit(1'b0);
      tx_valid = 1'b1;
      tx_flit = f;
      exp_v = m_crd > 0;
      n_cmp++; if (tx_ready !== exp_v) begin n_bad++; $display("FAIL tx_ready[%0d]: got %b want %b", k, tx_ready, exp_v); end
      if (exp_v) m_crd--;
      step();
      n_cmp++; if (TXFLITV !== exp_v || (exp_v && TXFLIT !== f)) begin n_bad++; $display("FAIL tx_flit[%0d]: got v=%b %h want v=%b %h", k, TXFLITV, TXFLIT, exp_v, f); end
      sent += int'(TXFLITV);
    end
    tx_valid = 1'b0;
    n_cmp++; if (sent != n + 1) begin n_bad++; $display("FAIL tx_sent_count: got %0d want %0d", sent, n + 1); end
    n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL tx_ready_exhausted: got %b want 0", tx_ready); end
    TXLCRDV = 1'b1;
    step();
    f = rand_flit(1'b0);
    tx_valid = 1'b1;
    tx_flit = f;
    step();
    TXLCRDV = 1'b0;
    tx_valid = 1'b0;
    m_crd = 1;
    n_cmp++; if ({TXFLITV, tx_ready} !== 2'b11 || TXFLIT !== f) begin n_bad++; $display("FAIL tx_same_cycle: got v=%b rdy=%b %h want v=1 rdy=1 %h", TXFLITV, tx_ready, TXFLIT, f); end
  endtask
  task automatic test_rx_credits();
    logic [FW-1:0] q[$];
    logic [FW-1:0] f;
    int g;
    RXLINKACTIVEREQ = 1'b1;
    rx_ready = 1'b0;
    step();
    n_cmp++; if (RXLINKACTIVEACK !== 1'b1) begin n_bad++; $display("FAIL rx_ack_up: got %b want 1", RXLINKACTIVEACK); end
    g = 0;
    repeat (10) begin step(); g += int'(RXLCRDV); end
    n_cmp++; if (g != RXN) begin n_bad++; $display("FAIL rx_grants: got %0d want %0d", g, RXN); end
    for (int i = 0; i < RXN; i++) begin
      f = rand_flit(1'b0);
      q.push_back(f);
      RXFLITV = 1'b1;
      RXFLIT = f;
      step();
    end
    RXFLITV = 1'b0;
    n_cmp++; if (rx_valid !== 1'b1 || rx_flit !== q[0]) begin n_bad++; $display("FAIL rx_head: got v=%b %h want v=1 %h", rx_valid, rx_flit, q[0]); end
    g = 0;
    repeat (5) begin step(); g += int'(RXLCRDV); end
    n_cmp++; if (g != 0) begin n_bad++; $display("FAIL rx_no_grant_full: got %0d want 0", g); end
    rx_ready = 1'b1;
    g = 0;
    for (int i = 0; i < RXN; i++) begin
      n_cmp++; if (rx_valid !== 1'b1 || rx_flit !== q[0]) begin n_bad++; $display("FAIL rx_pop[%0d]: got v=%b %h want v=1 %h", i, rx_valid, rx_flit, q[0]); end
      void'(q.pop_front());
      step();
      g += int'(RXLCRDV);
    end
    rx_ready = 1'b0;
    repeat (8) begin step(); g += int'(RXLCRDV); end
    n_cmp++; if (rx_valid !== 1'b0 || g != RXN) begin n_bad++; $display("FAIL rx_regrant: got v=%b grants=%0d want v=0 grants=%0d", rx_valid, g, RXN); end
    for (int i = 0; i < 2; i++) begin
      f = rand_flit(1'b0);
      q.push_back(f);
      RXFLITV = 1'b1;
      RXFLIT = f;
      step();
    end
    RXFLITV = 1'b0;
    RXLINKACTIVEREQ = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      RXFLITV = 1'b1;
      RXFLIT = rand_flit(1'b1);
      step();
      RXFLITV = 1'b0;
      n_cmp++; if (RXLINKACTIVEACK !== 1'b1) begin n_bad++; $display("FAIL rx_deact_hold[%0d]: got %b want 1", i, RXLINKACTIVEACK); end
    end
    step();
    n_cmp++; if ({RXLINKACTIVEACK, RXLCRDV} !== 2'b00) begin n_bad++; $display("FAIL rx_ack_drop: got %b want 00", {RXLINKACTIVEACK, RXLCRDV}); end
    rx_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (rx_valid !== 1'b1 || rx_flit !== q[0]) begin n_bad++; $display("FAIL rx_drain[%0d]: got v=%b %h want v=1 %h", i, rx_valid, rx_flit, q[0]); end
      void'(q.pop_front());
      step();
    end
    rx_ready = 1'b0;
    n_cmp++; if ({rx_valid, proto_err} !== 2'b00) begin n_bad++; $display("FAIL rx_link_dropped: got %b want 00", {rx_valid, proto_err}); end
  endtask
  task automatic test_tx_teardown();
    int g;
    logic nz;
    repeat (2) begin TXLCRDV = 1'b1; step(); end
    TXLCRDV = 1'b0;
    m_crd += 2;
    link_en = 1'b0;
    step();
    n_cmp++; if ({TXLINKACTIVEREQ, TXSACTIVE, tx_ready} !== 3'b010) begin n_bad++; $display("FAIL tx_deact: got %b want 010", {TXLINKACTIVEREQ, TXSACTIVE, tx_ready}); end
    g = 0;
    nz = 1'b0;
    repeat (6) begin
      step();
      g += int'(TXFLITV);
      nz |= TXFLITV & (|TXFLIT);
    end
    n_cmp++; if (g != m_crd || nz !== 1'b0) begin n_bad++; $display("FAIL tx_link_flits: got %0d nonzero=%b want %0d nonzero=0", g, nz, m_crd); end
    m_crd = 0;
    n_cmp++; if (TXSACTIVE !== 1'b1) begin n_bad++; $display("FAIL tx_hold_ack: got %b want 1", TXSACTIVE); end
    TXLINKACTIVEACK = 1'b0;
    step();
    n_cmp++; if ({TXSACTIVE, TXLINKACTIVEREQ, proto_err} !== 3'b000) begin n_bad++; $display("FAIL tx_stop: got %b want 000", {TXSACTIVE, TXLINKACTIVEREQ, proto_err}); end
  endtask
  task automatic test_errors();
    do_reset();
    bring_up();
    repeat (CRD_MAX) begin TXLCRDV = 1'b1; step(); end
    TXLCRDV = 1'b0;
    n_cmp++; if ({proto_err, tx_ready} !== 2'b01) begin n_bad++; $display("FAIL crd_at_max: got %b want 01", {proto_err, tx_ready}); end
    TXLCRDV = 1'b1;
    step();
    TXLCRDV = 1'b0;
    n_cmp++; if (proto_err !== 1'b1) begin n_bad++; $display("FAIL crd_overflow: got %b want 1", proto_err); end
    do_reset();
    TXLCRDV = 1'b1;
    step();
    TXLCRDV = 1'b0;
    n_cmp++; if (proto_err !== 1'b1) begin n_bad++; $display("FAIL crd_in_stop: got %b want 1", proto_err); end
    bring_up();
    n_cmp++; if ({tx_ready, proto_err} !== 2'b01) begin n_bad++; $display("FAIL crd_stop_ignored: got %b want 01", {tx_ready, proto_err}); end
    do_reset();
    n_cmp++; if (proto_err !== 1'b0) begin n_bad++; $display("FAIL err_cleared: got %b want 0", proto_err); end
    RXFLITV = 1'b1;
    RXFLIT = rand_flit(1'b0);
    step();
    RXFLITV = 1'b0;
    n_cmp++; if ({proto_err, rx_valid} !== 2'b10) begin n_bad++; $display("FAIL rx_no_credit: got %b want 10", {proto_err, rx_valid}); end
    repeat (3) step();
    n_cmp++; if ({proto_err, rx_valid} !== 2'b10) begin n_bad++; $display("FAIL err_sticky: got %b want 10", {proto_err, rx_valid}); end
  endtask
  task automatic test_rst_mid();
    do_reset();
    bring_up();
    RXLINKACTIVEREQ = 1'b1;
    repeat (6) step();
    TXLCRDV = 1'b1;
    step();
    TXLCRDV = 1'b0;
    for (int i = 0; i < 2; i++) begin
      RXFLITV = 1'b1;
      RXFLIT = rand_flit(1'b0);
      step();
    end
    RXFLITV = 1'b0;
    n_cmp++; if ({rx_valid, RXLINKACTIVEACK, tx_ready} !== 3'b111) begin n_bad++; $display("FAIL rst_setup: got %b want 111", {rx_valid, RXLINKACTIVEACK, tx_ready}); end
    rst = 1'b1;
    step();
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL rst_mid_outputs: got %h want 0", outs); end
    rst = 1'b0;
    {link_en, TXLINKACTIVEACK, RXLINKACTIVEREQ} = '0;
    step();
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL rst_mid_fifo_empty: got %h want 0", outs); end
  endtask
  initial begin
    test_reset();
    test_bringup();
    test_tx_credits();
    test_rx_credits();
    test_tx_teardown();
    test_errors();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
